interface_dht_multicanal: RTL and testbench

//  Multi-channel single-wire reader for DHT11/DHT22 humidity/temperature sensors; successor of the single-channel DHT11 interface.
//  On a request, it measures one selected channel in the requested sensor mode, checks the checksum and retries on failure.
//  It returns the raw 40-bit frame. Sits between the main control FSM and the open-drain sensor buses.

---
 rtl/interface_dht_multicanal_pkg.sv | 35 +++
 rtl/sincronizador_dht.sv | 22 ++
 rtl/interface_dht_multicanal.sv | 251 +++++++++++++++++++++++++
 tb/tb_interface_dht_multicanal.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interface_dht_multicanal_pkg.sv
// Shared definitions for the multi-channel DHT reader: state codes,
// sensor mode constants, frame field offsets and the checksum test.
package interface_dht_multicanal_pkg;

  typedef enum logic [3:0] {
    OCIOSO       = 4'd0,
    INICIO       = 4'd1,
    AGUARDA_RESP = 4'd2,
    RESP_BAIXO   = 4'd3,
    RESP_ALTO    = 4'd4,
    BIT_BAIXO    = 4'd5,
    BIT_ALTO     = 4'd6,
    VERIFICA     = 4'd7,
    PAUSA        = 4'd8,
    FIM          = 4'd9
  } estado_t;

  localparam logic MODO_DHT11 = 1'b0;
  localparam logic MODO_DHT22 = 1'b1;

  localparam int unsigned BITS_QUADRO = 40;
  localparam int unsigned OFS_UR_HI   = 32;
  localparam int unsigned OFS_UR_LO   = 24;
  localparam int unsigned OFS_T_HI    = 16;
  localparam int unsigned OFS_T_LO    = 8;
  localparam int unsigned OFS_CHK     = 0;

  // 8-bit wrapping sum of the four data bytes must equal the checksum byte
  function automatic logic checksum_ok(input logic [BITS_QUADRO-1:0] q);
    logic [7:0] soma;
    soma = q[OFS_UR_HI +: 8] + q[OFS_UR_LO +: 8] + q[OFS_T_HI +: 8] + q[OFS_T_LO +: 8];
    return soma == q[OFS_CHK +: 8];
  endfunction

endpackage

// File: rtl/sincronizador_dht.sv
// Two-flop synchroniser for one sensor bus; idles high like the pulled-up bus.
module sincronizador_dht (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic saida
);

  logic meta;

  // Shift the raw bus level through two flops
  always_ff @(posedge clock) begin
    if (!reset) begin
      meta  <= 1'b1;
      saida <= 1'b1;
    end else begin
      meta  <= entrada;
      saida <= meta;
    end
  end

endmodule

// File: rtl/interface_dht_multicanal.sv
// Multi-channel DHT11/DHT22 single-wire reader: start pulse, response and
// 40-bit frame capture on one selected open-drain bus, checksum test, retries.
module interface_dht_multicanal
  import interface_dht_multicanal_pkg::*;
#(
  parameter int unsigned CANAIS       = 2,
  parameter int unsigned T_INICIO_11  = 900_000,
  parameter int unsigned T_INICIO_22  = 50_000,
  parameter int unsigned T_LIMIAR     = 2_500,
  parameter int unsigned TIMEOUT      = 5_000,
  parameter int unsigned T_PAUSA      = 100_000,
  parameter int unsigned RETENTATIVAS = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        medir,
  input  logic [$clog2(CANAIS):0]     canal,
  input  logic                        modo,
  inout  wire  [CANAIS-1:0]           dht_bus,
  output logic                        ocupado,
  output logic                        pronto,
  output logic [39:0]                 dados,
  output logic [$clog2(CANAIS):0]     canal_medido,
  output logic                        erro_checksum,
  output logic                        erro_timeout,
  output logic                        erro_canal,
  output logic [2:0]                  tentativas,
  output logic [3:0]                  db_estado
);

  localparam int unsigned CW      = $clog2(CANAIS) + 1;
  localparam int unsigned M_INI   = (T_INICIO_11 > T_INICIO_22) ? T_INICIO_11 : T_INICIO_22;
  localparam int unsigned M_ESP   = (TIMEOUT > T_PAUSA) ? TIMEOUT : T_PAUSA;
  localparam int unsigned M_ALL   = (M_INI > M_ESP) ? M_INI : M_ESP;
  localparam int unsigned CNT_MAX = (M_ALL > T_LIMIAR) ? M_ALL : T_LIMIAR;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  estado_t            estado;
  logic [CANAIS-1:0]  aciona;
  logic [CANAIS-1:0]  bus_sinc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   lim_inicio;
  logic [39:0]        quadro;
  logic [5:0]         nbits;
  logic               decidido;
  logic [3:0]         tent;
  logic [CW-1:0]      canal_r;
  logic               modo_r;
  logic               s_atual;
  logic               s_ant;
  logic               caiu;
  logic               subiu;
  logic               timeout_hit;
  logic               ultima;
  logic               falha_to;
  logic               falha_ck;

  for (genvar g = 0; g < CANAIS; g++) begin : g_canal
    assign dht_bus[g] = aciona[g] ? 1'b0 : 1'bz;

    sincronizador_dht u_sinc (
      .clock   (clock),
      .reset   (reset),
      .entrada (dht_bus[g]),
      .saida   (bus_sinc[g])
    );
  end

  assign s_atual     = bus_sinc[canal_r];
  assign caiu        = s_ant & ~s_atual;
  assign subiu       = ~s_ant & s_atual;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign ultima      = (tent > 4'(RETENTATIVAS));
  assign lim_inicio  = (modo_r == MODO_DHT22) ? CNT_W'(T_INICIO_22 - 1) : CNT_W'(T_INICIO_11 - 1);
  assign tentativas  = tent[2:0];
  assign db_estado   = estado;

  // Detect a failed attempt: edge wait expired, or bad checksum
  always_comb begin
    falha_to = 1'b0;
    falha_ck = 1'b0;
    unique case (estado)
      AGUARDA_RESP, RESP_ALTO, BIT_ALTO: falha_to = !caiu && timeout_hit;
      RESP_BAIXO, BIT_BAIXO:             falha_to = !subiu && timeout_hit;
      VERIFICA:                          falha_ck = !checksum_ok(quadro);
      default: ;
    endcase
  end

  // Measurement FSM with counters, shift register and registered outputs.
  // Edges are detected against the previous synchronised sample, so the
  // host's own low pulse still draining through the synchroniser after
  // release is never mistaken for the sensor's response.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado        <= OCIOSO;
      aciona        <= '0;
      cnt           <= '0;
      quadro        <= '0;
      nbits         <= '0;
      decidido      <= 1'b0;
      tent          <= '0;
      canal_r       <= '0;
      modo_r        <= 1'b0;
      s_ant         <= 1'b1;
      ocupado       <= 1'b0;
      pronto        <= 1'b0;
      dados         <= '0;
      canal_medido  <= '0;
      erro_checksum <= 1'b0;
      erro_timeout  <= 1'b0;
      erro_canal    <= 1'b0;
    end else begin
      pronto <= 1'b0;
      s_ant  <= s_atual;
      if (falha_to || falha_ck) begin
        cnt      <= '0;
        quadro   <= '0;
        nbits    <= '0;
        decidido <= 1'b0;
        if (ultima) begin
          estado        <= FIM;
          pronto        <= 1'b1;
          ocupado       <= 1'b0;
          erro_timeout  <= falha_to;
          erro_checksum <= falha_ck;
          if (falha_ck) begin
            dados        <= quadro;
            canal_medido <= canal_r;
          end
        end else begin
          estado <= PAUSA;
          tent   <= tent + 4'd1;
        end
      end else begin
        unique case (estado)
          OCIOSO: begin
            if (medir) begin
              erro_checksum <= 1'b0;
              erro_timeout  <= 1'b0;
              if (canal >= CW'(CANAIS)) begin
                erro_canal <= 1'b1;
                pronto     <= 1'b1;
                tent       <= '0;
              end else begin
                erro_canal     <= 1'b0;
                canal_r        <= canal;
                modo_r         <= modo;
                ocupado        <= 1'b1;
                tent           <= 4'd1;
                cnt            <= '0;
                quadro         <= '0;
                nbits          <= '0;
                decidido       <= 1'b0;
                aciona         <= '0;
                aciona[canal]  <= 1'b1;
                estado         <= INICIO;
              end
            end
          end
          INICIO: begin
            if (cnt == lim_inicio) begin
              aciona <= '0;
              cnt    <= '0;
              estado <= AGUARDA_RESP;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          AGUARDA_RESP: begin
            cnt <= cnt + CNT_W'(1);
            if (caiu) begin
              cnt    <= '0;
              estado <= RESP_BAIXO;
            end
          end
          RESP_BAIXO: begin
            cnt <= cnt + CNT_W'(1);
            if (subiu) begin
              cnt    <= '0;
              estado <= RESP_ALTO;
            end
          end
          RESP_ALTO: begin
            cnt <= cnt + CNT_W'(1);
            if (caiu) begin
              cnt    <= '0;
              estado <= BIT_BAIXO;
            end
          end
          BIT_BAIXO: begin
            cnt <= cnt + CNT_W'(1);
            if (subiu) begin
              cnt      <= '0;
              decidido <= 1'b0;
              estado   <= BIT_ALTO;
            end
          end
          BIT_ALTO: begin
            cnt <= cnt + CNT_W'(1);
            if (caiu && !decidido) begin
              quadro <= {quadro[38:0], 1'b0};
              nbits  <= nbits + 6'd1;
              cnt    <= '0;
              estado <= (nbits == 6'd39) ? VERIFICA : BIT_BAIXO;
            end else if (caiu) begin
              cnt      <= '0;
              decidido <= 1'b0;
              estado   <= BIT_BAIXO;
            end else if (!decidido && cnt == CNT_W'(T_LIMIAR - 1)) begin
              quadro   <= {quadro[38:0], 1'b1};
              nbits    <= nbits + 6'd1;
              decidido <= 1'b1;
              if (nbits == 6'd39) begin
                cnt    <= '0;
                estado <= VERIFICA;
              end
            end
          end
          VERIFICA: begin
            estado        <= FIM;
            pronto        <= 1'b1;
            ocupado       <= 1'b0;
            dados         <= quadro;
            canal_medido  <= canal_r;
            erro_checksum <= 1'b0;
            erro_timeout  <= 1'b0;
          end
          PAUSA: begin
            if (cnt == CNT_W'(T_PAUSA - 1)) begin
              cnt             <= '0;
              aciona          <= '0;
              aciona[canal_r] <= 1'b1;
              estado          <= INICIO;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          FIM: begin
            estado <= OCIOSO;
          end
          default: begin
            estado <= OCIOSO;
            aciona <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_interface_dht_multicanal.sv
// Directed bench for interface_dht_multicanal with a behavioural sensor model
// on each pulled-up bus and scaled-down timing parameters.
module tb_interface_dht_multicanal;

  localparam int unsigned CANAIS = 2;
  localparam int unsigned TI11   = 300;
  localparam int unsigned TI22   = 120;
  localparam int unsigned TLIM   = 40;
  localparam int unsigned TOUT   = 150;
  localparam int unsigned TPAU   = 400;
  localparam int unsigned RET    = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        medir = 1'b0;
  logic [1:0]  canal = '0;
  logic        modo  = 1'b0;
  wire  [1:0]  dht_bus;
  logic [1:0]  sens_drv = '0;

  logic        ocupado;
  logic        pronto;
  logic [39:0] dados;
  logic [1:0]  canal_medido;
  logic        erro_checksum;
  logic        erro_timeout;
  logic        erro_canal;
  logic [2:0]  tentativas;
  logic [3:0]  db_estado;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  int pronto_cnt = 0;
  int host_low0  = 0;
  int host_low1  = 0;

  interface_dht_multicanal #(
    .CANAIS       (CANAIS),
    .T_INICIO_11  (TI11),
    .T_INICIO_22  (TI22),
    .T_LIMIAR     (TLIM),
    .TIMEOUT      (TOUT),
    .T_PAUSA      (TPAU),
    .RETENTATIVAS (RET)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .medir         (medir),
    .canal         (canal),
    .modo          (modo),
    .dht_bus       (dht_bus),
    .ocupado       (ocupado),
    .pronto        (pronto),
    .dados         (dados),
    .canal_medido  (canal_medido),
    .erro_checksum (erro_checksum),
    .erro_timeout  (erro_timeout),
    .erro_canal    (erro_canal),
    .tentativas    (tentativas),
    .db_estado     (db_estado)
  );

  pullup (dht_bus[0]);
  pullup (dht_bus[1]);
  assign dht_bus[0] = sens_drv[0] ? 1'b0 : 1'bz;
  assign dht_bus[1] = sens_drv[1] ? 1'b0 : 1'bz;

  always #5 clock = ~clock;

  // Cycle stamp used for pulse-length and gap measurements
  always @(posedge clock) ncyc <= ncyc + 1;

  // Count pronto pulses and host-driven low cycles per bus
  always @(negedge clock) begin
    if (pronto === 1'b1) pronto_cnt <= pronto_cnt + 1;
    if (dht_bus[0] === 1'b0 && !sens_drv[0]) host_low0 <= host_low0 + 1;
    if (dht_bus[1] === 1'b0 && !sens_drv[1]) host_low1 <= host_low1 + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_medir(input logic [1:0] ch, input logic md);
    @(negedge clock);
    canal = ch;
    modo  = md;
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
  endtask

  // Wait for the host start pulse on a bus; stamps its first low and release cycles
  task automatic watch_start(input int ch, output int t_low, output int t_rel, output bit ok);
    ok = 1'b0;
    t_low = 0;
    t_rel = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clock);
      if (dht_bus[ch] === 1'b0) begin
        ok = 1'b1;
        t_low = ncyc;
      end
    end
    if (!ok) return;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clock);
      if (dht_bus[ch] !== 1'b0) begin
        t_rel = ncyc;
        break;
      end
    end
  endtask

  task automatic wait_pronto(input int maxc, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clock);
      if (pronto === 1'b1) begin
        ok = 1'b1;
        t  = ncyc;
      end
    end
  endtask

  // Sensor reply after host release; optionally resets the DUT inside bit abort_bit
  task automatic sensor_send(input int ch, input logic [39:0] q, input int abort_bit, output int t_end);
    cyc(20);
    sens_drv[ch] = 1'b1; cyc(80);
    sens_drv[ch] = 1'b0; cyc(80);
    t_end = 0;
    for (int i = 0; i < 40; i++) begin
      sens_drv[ch] = 1'b1; cyc(50);
      sens_drv[ch] = 1'b0;
      t_end = ncyc;
      if (i == abort_bit) begin
        cyc(10);
        chk("estado_bit_alto", 64'(db_estado), 64'd6);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_bus",        64'(dht_bus),       64'h3);
        chk("rst_estado",     64'(db_estado),     64'd0);
        chk("rst_ocupado",    64'(ocupado),       64'd0);
        chk("rst_pronto",     64'(pronto),        64'd0);
        chk("rst_dados",      64'(dados),         64'd0);
        chk("rst_tentativas", 64'(tentativas),    64'd0);
        chk("rst_erros",      64'({erro_checksum, erro_timeout, erro_canal}), 64'd0);
        chk("rst_canal_med",  64'(canal_medido),  64'd0);
        return;
      end
      if (i == 39) begin
        // a final '1' needs no closing fall; a final '0' ends with the 50-cycle low
        if (!q[39-i]) begin
          cyc(26);
          sens_drv[ch] = 1'b1; cyc(50);
          sens_drv[ch] = 1'b0;
          t_end = ncyc;
        end
      end else if (q[39-i]) begin
        cyc(70);
      end else begin
        cyc(26);
      end
    end
  endtask

  int  tl, tr, tr_prev, te, tp, p0, h0, h1;
  bit  ok, okp;

  initial begin
    // reset state
    cyc(3);
    chk("reset_estado",  64'(db_estado),  64'd0);
    chk("reset_ocupado", 64'(ocupado),    64'd0);
    chk("reset_dados",   64'(dados),      64'd0);
    chk("reset_bus",     64'(dht_bus),    64'h3);
    reset = 1'b1;
    cyc(3);

    // 1: DHT11 on ch0
    p0 = pronto_cnt;
    fork
      begin
        watch_start(0, tl, tr, ok);
        chk("t1_start_seen", 64'(ok), 64'd1);
        chk("t1_low_len", 64'(tr - tl), 64'(TI11));
        if (ok) sensor_send(0, 40'h123422026A, -1, te);
      end
      begin
        pulse_medir(2'd0, 1'b0);
        chk("t1_ocupado", 64'(ocupado), 64'd1);
        chk("t1_estado_inicio", 64'(db_estado), 64'd1);
        wait_pronto(20000, tp, okp);
        chk("t1_pronto_seen", 64'(okp), 64'd1);
      end
    join
    cyc(3);
    chk("t1_dados", 64'(dados), 64'h123422026A);
    chk("t1_erros", 64'({erro_checksum, erro_timeout, erro_canal}), 64'd0);
    chk("t1_tentativas", 64'(tentativas), 64'd1);
    chk("t1_canal_med", 64'(canal_medido), 64'd0);
    chk("t1_pronto_cnt", 64'(pronto_cnt - p0), 64'd1);
    chk("t1_ocupado_fim", 64'(ocupado), 64'd0);

    // 2: DHT22 on ch1, ch0 untouched, medir mid-frame ignored
    p0 = pronto_cnt;
    h0 = host_low0;
    fork
      begin
        watch_start(1, tl, tr, ok);
        chk("t2_start_seen", 64'(ok), 64'd1);
        chk("t2_low_len", 64'(tr - tl), 64'(TI22));
        if (ok) sensor_send(1, 40'h2345AAB2C4, -1, te);
      end
      begin
        pulse_medir(2'd1, 1'b1);
        cyc(500);
        pulse_medir(2'd3, 1'b0);
        chk("t2_medir_ignored", 64'({ocupado, erro_canal, pronto}), 64'b100);
        wait_pronto(20000, tp, okp);
        chk("t2_pronto_seen", 64'(okp), 64'd1);
      end
    join
    cyc(5);
    chk("t2_dados", 64'(dados), 64'h2345AAB2C4);
    chk("t2_canal_med", 64'(canal_medido), 64'd1);
    chk("t2_erros", 64'({erro_checksum, erro_timeout, erro_canal}), 64'd0);
    chk("t2_ch0_idle", 64'(host_low0 - h0), 64'd0);
    chk("t2_pronto_cnt", 64'(pronto_cnt - p0), 64'd1);

    // 3: persistent checksum error on ch0, DHT22
    p0 = pronto_cnt;
    fork
      begin
        te = 0;
        for (int a = 0; a < 3; a++) begin
          watch_start(0, tl, tr, ok);
          chk("t3_start_seen", 64'(ok), 64'd1);
          chk("t3_low_len", 64'(tr - tl), 64'(TI22));
          if (a > 0) chk("t3_pause_ge", 64'((tl - te) >= int'(TPAU)), 64'd1);
          if (ok) sensor_send(0, 40'h2345AAB2AB, -1, te);
        end
      end
      begin
        pulse_medir(2'd0, 1'b1);
        wait_pronto(40000, tp, okp);
        chk("t3_pronto_seen", 64'(okp), 64'd1);
      end
    join
    cyc(3);
    chk("t3_erro_checksum", 64'(erro_checksum), 64'd1);
    chk("t3_erro_timeout", 64'(erro_timeout), 64'd0);
    chk("t3_tentativas", 64'(tentativas), 64'd3);
    chk("t3_dados", 64'(dados), 64'h2345AAB2AB);
    chk("t3_pronto_cnt", 64'(pronto_cnt - p0), 64'd1);

    // 4: silent sensor on ch1, DHT11; dados/canal_medido held
    p0 = pronto_cnt;
    tr_prev = 0;
    fork
      begin
        for (int a = 0; a < 3; a++) begin
          watch_start(1, tl, tr, ok);
          chk("t4_start_seen", 64'(ok), 64'd1);
          chk("t4_low_len", 64'(tr - tl), 64'(TI11));
          if (a > 0) chk("t4_gap", 64'(tl - tr_prev), 64'(TOUT + TPAU));
          tr_prev = tr;
        end
      end
      begin
        pulse_medir(2'd1, 1'b0);
        wait_pronto(40000, tp, okp);
        chk("t4_pronto_seen", 64'(okp), 64'd1);
      end
    join
    chk("t4_pronto_after_release", 64'(tp - tr_prev), 64'(TOUT));
    cyc(3);
    chk("t4_erro_timeout", 64'(erro_timeout), 64'd1);
    chk("t4_erro_checksum", 64'(erro_checksum), 64'd0);
    chk("t4_tentativas", 64'(tentativas), 64'd3);
    chk("t4_dados_held", 64'(dados), 64'h2345AAB2AB);
    chk("t4_canal_held", 64'(canal_medido), 64'd0);
    chk("t4_pronto_cnt", 64'(pronto_cnt - p0), 64'd1);

    // 5: invalid channel
    h0 = host_low0;
    h1 = host_low1;
    @(negedge clock);
    canal = 2'd3;
    modo  = 1'b0;
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    chk("t5_pronto", 64'(pronto), 64'd1);
    chk("t5_erro_canal", 64'(erro_canal), 64'd1);
    chk("t5_ocupado", 64'(ocupado), 64'd0);
    chk("t5_erro_timeout_clr", 64'(erro_timeout), 64'd0);
    cyc(1);
    chk("t5_pronto_pulse", 64'(pronto), 64'd0);
    cyc(20);
    chk("t5_no_bus", 64'((host_low0 - h0) + (host_low1 - h1)), 64'd0);

    // 6: reset inside bit 20 of a frame on ch0
    p0 = pronto_cnt;
    fork
      begin
        watch_start(0, tl, tr, ok);
        chk("t6_start_seen", 64'(ok), 64'd1);
        if (ok) sensor_send(0, 40'h123422026A, 19, te);
      end
      pulse_medir(2'd0, 1'b0);
    join
    cyc(5);
    reset = 1'b1;
    cyc(400);
    chk("t6_no_pronto", 64'(pronto_cnt - p0), 64'd0);

    // 7: normal measurement after the aborted one
    p0 = pronto_cnt;
    fork
      begin
        watch_start(1, tl, tr, ok);
        chk("t7_start_seen", 64'(ok), 64'd1);
        chk("t7_low_len", 64'(tr - tl), 64'(TI22));
        if (ok) sensor_send(1, 40'h010203040A, -1, te);
      end
      begin
        pulse_medir(2'd1, 1'b1);
        wait_pronto(20000, tp, okp);
        chk("t7_pronto_seen", 64'(okp), 64'd1);
      end
    join
    cyc(3);
    chk("t7_dados", 64'(dados), 64'h010203040A);
    chk("t7_tentativas", 64'(tentativas), 64'd1);
    chk("t7_canal_med", 64'(canal_medido), 64'd1);
    chk("t7_erros", 64'({erro_checksum, erro_timeout, erro_canal}), 64'd0);
    chk("t7_pronto_cnt", 64'(pronto_cnt - p0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
